// File: rtl/token_drop_animator.sv
// ---------------------------------------------------------------------------
// token_drop_animator
//   Animates a token falling down a board column. The token moves down one
//   row every STEP_CYCLES clocks and stops above the first occupied cell or
//   on the bottom row. On landing it issues a one-cycle token_ready pulse
//   together with final_row/final_column.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   player_move   one-cycle move request
//   column_index  requested column 0..6, sampled with player_move
//   player_turn   0 = red, 1 = green, sampled with player_move
//   board_red     committed red tokens   [row][bit], column c -> bit COLS-1-c
//   board_grn     committed green tokens [row][bit], column c -> bit COLS-1-c
//   falling_red   overlay of the falling red token (at most one bit set)
//   falling_grn   overlay of the falling green token (at most one bit set)
//   busy          high from request acceptance until token_ready is issued
//   token_ready   one-cycle landing pulse
//   final_row     row of the last landed token
//   final_column  column of the last landed token
// ---------------------------------------------------------------------------
module token_drop_animator #(
    parameter int unsigned STEP_CYCLES = 12500000,
    parameter int unsigned ROWS        = 6,
    parameter int unsigned COLS        = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      player_move,
    input  logic [2:0]                column_index,
    input  logic                      player_turn,
    input  logic [ROWS-1:0][COLS-1:0] board_red,
    input  logic [ROWS-1:0][COLS-1:0] board_grn,
    output logic [ROWS-1:0][COLS-1:0] falling_red,
    output logic [ROWS-1:0][COLS-1:0] falling_grn,
    output logic                      busy,
    output logic                      token_ready,
    output logic [2:0]                final_row,
    output logic [2:0]                final_column
);

    localparam int unsigned CNT_W = $clog2(STEP_CYCLES + 1);
    localparam int unsigned BIT_W = $clog2(COLS);
    localparam int unsigned OV_W  = ROWS * COLS;

    localparam logic [2:0]       MAX_COL  = 3'd6;
    localparam logic [2:0]       LAST_ROW = 3'(ROWS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FALL = 2'd1,
        LAND = 2'd2
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        row_q;
    logic [2:0]        col_q;
    logic              colour_q;

    logic [BIT_W-1:0]  req_bit_c;
    logic [BIT_W-1:0]  cur_bit_c;
    logic [COLS-1:0]   req_onehot_c;
    logic              req_top_occ_c;
    logic              req_ok_c;
    logic              below_occ_c;
    logic              land_c;

    // Board bit positions of the requested and the latched column.
    assign req_bit_c = BIT_W'(COLS - 1) - BIT_W'(column_index);
    assign cur_bit_c = BIT_W'(COLS - 1) - BIT_W'(col_q);

    // A request is accepted only for a legal column with a free top cell.
    assign req_top_occ_c = board_red[0][req_bit_c] | board_grn[0][req_bit_c];
    assign req_ok_c      = player_move && (column_index <= MAX_COL) && !req_top_occ_c;
    assign req_onehot_c  = COLS'(1) << req_bit_c;

    // Live occupancy of the cell directly below the token; none below the last row.
    always_comb begin
        below_occ_c = 1'b0;
        for (int r = 0; r < int'(ROWS) - 1; r++) begin
            if (row_q == 3'(r)) begin
                below_occ_c = board_red[r+1][cur_bit_c] | board_grn[r+1][cur_bit_c];
            end
        end
    end

    assign land_c = (row_q == LAST_ROW) || below_occ_c;

    // Animation state machine with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            colour_q     <= 1'b0;
            falling_red  <= '0;
            falling_grn  <= '0;
            busy         <= 1'b0;
            token_ready  <= 1'b0;
            final_row    <= '0;
            final_column <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_ok_c) begin
                        state_q  <= FALL;
                        cnt_q    <= '0;
                        row_q    <= '0;
                        col_q    <= column_index;
                        colour_q <= player_turn;
                        busy     <= 1'b1;
                        // Row 0 occupies the low COLS bits of the overlay.
                        if (player_turn) begin
                            falling_grn <= OV_W'(req_onehot_c);
                        end else begin
                            falling_red <= OV_W'(req_onehot_c);
                        end
                    end
                end

                FALL: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (land_c) begin
                            state_q      <= LAND;
                            token_ready  <= 1'b1;
                            final_row    <= row_q;
                            final_column <= col_q;
                        end else begin
                            row_q <= row_q + 3'd1;
                            // Moving down one row is a shift by one row width;
                            // the unused colour's overlay is zero and stays so.
                            falling_red <= falling_red << COLS;
                            falling_grn <= falling_grn << COLS;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                LAND: begin
                    state_q     <= IDLE;
                    token_ready <= 1'b0;
                    busy        <= 1'b0;
                    falling_red <= '0;
                    falling_grn <= '0;
                end

                default: begin
                    state_q     <= IDLE;
                    token_ready <= 1'b0;
                    busy        <= 1'b0;
                    falling_red <= '0;
                    falling_grn <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_token_drop_animator.sv
module tb_token_drop_animator;

    localparam int unsigned S    = 4;
    localparam int unsigned ROWS = 6;
    localparam int unsigned COLS = 16;
    localparam int unsigned OW   = ROWS * COLS;

    logic                      clk;
    logic                      reset;
    logic                      player_move;
    logic [2:0]                column_index;
    logic                      player_turn;
    logic [ROWS-1:0][COLS-1:0] board_red;
    logic [ROWS-1:0][COLS-1:0] board_grn;
    logic [ROWS-1:0][COLS-1:0] falling_red;
    logic [ROWS-1:0][COLS-1:0] falling_grn;
    logic                      busy;
    logic                      token_ready;
    logic [2:0]                final_row;
    logic [2:0]                final_column;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    token_drop_animator #(
        .STEP_CYCLES(S),
        .ROWS       (ROWS),
        .COLS       (COLS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .player_move (player_move),
        .column_index(column_index),
        .player_turn (player_turn),
        .board_red   (board_red),
        .board_grn   (board_grn),
        .falling_red (falling_red),
        .falling_grn (falling_grn),
        .busy        (busy),
        .token_ready (token_ready),
        .final_row   (final_row),
        .final_column(final_column)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Token position is derived from time since acceptance: a decision is
    // taken every S clocks, landing if the next cell is the floor or occupied.
    bit m_active;
    bit m_land;
    bit m_colour;
    int m_row;
    int m_col;
    int m_t;
    int m_fr;
    int m_fc;

    function automatic bit occ(input int r, input int c);
        return board_red[r][COLS-1-c] | board_grn[r][COLS-1-c];
    endfunction

    function automatic logic [ROWS-1:0][COLS-1:0] ov(input bit en, input int r, input int c);
        logic [ROWS-1:0][COLS-1:0] v;
        v = '0;
        if (en) v[r][COLS-1-c] = 1'b1;
        return v;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active = 0; m_land = 0; m_row = 0; m_t = 0; m_fr = 0; m_fc = 0;
        end else if (m_land) begin
            m_land   = 0;
            m_active = 0;
        end else if (m_active) begin
            m_t++;
            if (m_t == (m_row + 1) * int'(S)) begin
                if (m_row == int'(ROWS) - 1 || occ(m_row + 1, m_col)) begin
                    m_land = 1; m_fr = m_row; m_fc = m_col;
                end else begin
                    m_row++;
                end
            end
        end else if (player_move && column_index <= 3'd6 && !occ(0, int'(column_index))) begin
            m_active = 1; m_row = 0; m_t = 0;
            m_col    = int'(column_index);
            m_colour = player_turn;
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            check("busy",         OW'(busy),         OW'(m_active));
            check("token_ready",  OW'(token_ready),  OW'(m_land));
            check("final_row",    OW'(final_row),    OW'(m_fr));
            check("final_column", OW'(final_column), OW'(m_fc));
            check("falling_red",  OW'(falling_red),  OW'(ov(m_active && !m_colour, m_row, m_col)));
            check("falling_grn",  OW'(falling_grn),  OW'(ov(m_active && m_colour, m_row, m_col)));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic move(input int col, input bit turn);
        @(negedge clk);
        player_move  = 1'b1;
        column_index = 3'(col);
        player_turn  = turn;
        @(negedge clk);
        player_move  = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!token_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!token_ready) check("ready_timeout", OW'(0), OW'(1));
    endtask

    int n;
    int pulses;

    initial begin
        reset        = 1'b0;
        player_move  = 1'b0;
        column_index = 3'd0;
        player_turn  = 1'b0;
        board_red    = '0;
        board_grn    = '0;
        #2 reset = 1'b1;
        #20;
        check("rst_busy",  OW'(busy),        OW'(0));
        check("rst_ready", OW'(token_ready), OW'(0));
        check("rst_ovl",   OW'(falling_red) | OW'(falling_grn), OW'(0));
        check("rst_final", OW'({final_row, final_column}), OW'(0));
        @(negedge clk);
        reset  = 1'b0;
        cmp_en = 1;

        // Empty board, column 3 red: bit 12 walks rows 0..5, lands after 24 clocks.
        move(3, 0);
        n = 0;
        while (!token_ready && n < 200) begin
            if (n < 24) check("t1_ovl", OW'(falling_red[n/4][12]), OW'(1));
            @(negedge clk);
            n++;
        end
        check("t1_latency", OW'(n), OW'(24));
        check("t1_row",     OW'(final_row), OW'(5));
        check("t1_col",     OW'(final_column), OW'(3));
        @(negedge clk);
        check("t1_busy_drop", OW'(busy), OW'(0));

        // Column 0 partially filled, green lands at row 3 after 16 clocks.
        board_grn[5][15] = 1'b1;
        board_red[4][15] = 1'b1;
        move(0, 1);
        wait_ready(n);
        check("t2_latency", OW'(n), OW'(16));
        check("t2_row",     OW'(final_row), OW'(3));
        check("t2_ovl",     OW'(falling_grn[3][15]), OW'(1));
        @(negedge clk);
        board_red = '0;
        board_grn = '0;

        // Full top cell in column 6: request ignored.
        board_red[0][9] = 1'b1;
        move(6, 0);
        repeat (3) begin
            check("t3_busy", OW'(busy), OW'(0));
            check("t3_ovl",  OW'(falling_red) | OW'(falling_grn), OW'(0));
            @(negedge clk);
        end
        board_red = '0;

        // Second request mid-fall is dropped.
        move(2, 0);
        repeat (5) @(negedge clk);
        move(1, 1);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (token_ready) pulses++;
        end
        check("t4_pulses", OW'(pulses), OW'(1));
        check("t4_col",    OW'(final_column), OW'(2));

        // Reset at row 2 aborts immediately; next move starts at row 0.
        move(0, 0);
        repeat (9) @(negedge clk);
        check("t5_row2", OW'(falling_red[2][15]), OW'(1));
        #2 reset = 1'b1;
        #1;
        check("t5_ovl",   OW'(falling_red) | OW'(falling_grn), OW'(0));
        check("t5_busy",  OW'(busy), OW'(0));
        check("t5_ready", OW'(token_ready), OW'(0));
        @(negedge clk);
        reset = 1'b0;
        move(4, 1);
        check("t5_restart", OW'(falling_grn[0][11]), OW'(1));
        check("t5_busy2",   OW'(busy), OW'(1));
        wait_ready(n);
        check("t5_latency", OW'(n), OW'(24));
        @(negedge clk);

        // Illegal column 7.
        move(7, 0);
        repeat (2) begin
            check("t6_busy", OW'(busy), OW'(0));
            @(negedge clk);
        end

        // Random phase: random boards (also changing mid-fall) and requests.
        repeat (3000) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) begin
                for (int r = 0; r < int'(ROWS); r++) begin
                    board_red[r] = COLS'($urandom) & COLS'($urandom);
                    board_grn[r] = COLS'($urandom) & COLS'($urandom) & ~board_red[r];
                end
                if ($urandom_range(0, 1) == 0) board_red[0] = '0;
                if ($urandom_range(0, 1) == 0) board_grn[0] = '0;
            end
            player_move  = ($urandom_range(0, 3) == 0);
            column_index = 3'($urandom_range(0, 7));
            player_turn  = 1'($urandom_range(0, 1));
        end
        player_move = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("final_idle", OW'(busy), OW'(0));
        @(negedge clk);
        cmp_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
